spi_master_shifter: RTL

//  SPI master transfer engine, directly downstream of the SPI baud-rate generator.

---
 rtl/spi_master_shifter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_shifter.sv
// SPI master transfer engine: drives the baud generator enable, edge-detects its
// Baudclk output and produces SCK/MOSI/CSn while shifting one DATA_W-bit word.
module spi_master_shifter #(
    parameter int   DATA_W    = 8,
    parameter logic CPOL      = 1'b0,
    parameter int   CPHA      = 0,
    parameter int   MSB_FIRST = 1,
    parameter int   CS_SETUP  = 2,
    parameter int   CS_HOLD   = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Start,
    input  logic [DATA_W-1:0] Tx_Data,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Rx_Data,
    output logic              Baud_En,
    input  logic              Baudclk,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CSn,
    output logic [1:0]        Dbg_State
);

    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] SETUP_LAST = GAP_W'(CS_SETUP - 1);
    localparam logic [GAP_W-1:0] HOLD_LAST  = GAP_W'(CS_HOLD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD} state_t;

    state_t              state_q;
    logic                baud_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [DATA_W-1:0]   tx_sr_q, rx_sr_q, rx_data_q;
    logic                csn_q, sck_q, mosi_q, baud_en_q, busy_q, done_q;

    logic                lead, trail;
    logic                first_bit, next_bit;
    logic [DATA_W-1:0]   first_shift_d, tx_shift_d, rx_shift_d;

    // Handshake: Start is a one-cycle request taken only in IDLE (which includes the
    // Done cycle); Busy rises the next cycle and holds until Done, which pulses once
    // with Rx_Data valid in that same cycle.
    assign lead  = (Baudclk != baud_q) && (Baudclk != CPOL);
    assign trail = (Baudclk != baud_q) && (Baudclk == CPOL);

    always_comb begin
        first_bit     = Tx_Data[0];
        next_bit      = tx_sr_q[0];
        first_shift_d = {1'b0, Tx_Data[DATA_W-1:1]};
        tx_shift_d    = {1'b0, tx_sr_q[DATA_W-1:1]};
        rx_shift_d    = {MISO, rx_sr_q[DATA_W-1:1]};
        if (MSB_FIRST != 0) begin
            first_bit     = Tx_Data[DATA_W-1];
            next_bit      = tx_sr_q[DATA_W-1];
            first_shift_d = {Tx_Data[DATA_W-2:0], 1'b0};
            tx_shift_d    = {tx_sr_q[DATA_W-2:0], 1'b0};
            rx_shift_d    = {rx_sr_q[DATA_W-2:0], MISO};
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            baud_q    <= CPOL;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            csn_q     <= 1'b1;
            sck_q     <= CPOL;
            mosi_q    <= 1'b0;
            baud_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            baud_q <= Baudclk;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sck_q <= CPOL;
                    if (Start) begin
                        state_q   <= ST_SETUP;
                        csn_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        gap_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        rx_sr_q   <= '0;
                        if (CPHA == 0) begin
                            mosi_q  <= first_bit;
                            tx_sr_q <= first_shift_d;
                        end else begin
                            tx_sr_q <= Tx_Data;
                        end
                    end
                end
                ST_SETUP: begin
                    sck_q <= CPOL;
                    if (gap_cnt_q == SETUP_LAST) begin
                        baud_en_q <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= ST_XFER;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                ST_XFER: begin
                    sck_q <= Baudclk;
                    if (lead) begin
                        if (CPHA == 0) begin
                            rx_sr_q <= rx_shift_d;
                        end else begin
                            mosi_q  <= next_bit;
                            tx_sr_q <= tx_shift_d;
                        end
                    end
                    if (trail) begin
                        if (CPHA != 0) rx_sr_q <= rx_shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        // The final trailing edge ends the word; nothing further is shifted out.
                        if (bit_cnt_q == LAST_BIT) begin
                            baud_en_q <= 1'b0;
                            gap_cnt_q <= '0;
                            state_q   <= ST_HOLD;
                        end else if (CPHA == 0) begin
                            mosi_q  <= next_bit;
                            tx_sr_q <= tx_shift_d;
                        end
                    end
                end
                ST_HOLD: begin
                    sck_q <= CPOL;
                    if (gap_cnt_q == HOLD_LAST) begin
                        csn_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sr_q;
                        mosi_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Rx_Data   = rx_data_q;
    assign Baud_En   = baud_en_q;
    assign SCK       = sck_q;
    assign MOSI      = mosi_q;
    assign CSn       = csn_q;
    assign Dbg_State = state_q;

endmodule
